exc_ctrl: RTL and testbench

Exception/interrupt sequencer for the CP0 register file, sitting at the MEM/commit stage. It detects exceptions, ERET and enabled interrupts on the committing instruction and owns the single CP0 write port. It serialises the EPC/Cause/BadVAddr/Status updates over successive cycles, then issues a PC redirect. While idle it passes MTC0 writes through to CP0 unchanged.

---
 rtl/exc_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_exc_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt sequencer at the MEM/commit stage.
// Detects exceptions, ERET and enabled interrupts on the committing
// instruction, serialises the EPC/Cause/BadVAddr/Status writes through the
// single CP0 write port, then issues a PC redirect. While idle, MTC0 writes
// pass straight through to the CP0 write port.
//
// Ports:
//   clk, rst (sync, active-low)
//   exc_valid, exc_type[6:0], eret, inst_pc, in_delay_slot, data_addr
//   cp0_status, cp0_cause, cp0_epc      live CP0 taps
//   mtc0_en, mtc0_addr, mtc0_data       MTC0 write request
//   cp0_we, cp0_waddr, cp0_wdata        CP0 write port
//   flush, stall, redirect_valid, redirect_pc, busy
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [6:0]  exc_type,
    input  logic        eret,
    input  logic [31:0] inst_pc,
    input  logic        in_delay_slot,
    input  logic [31:0] data_addr,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic        mtc0_en,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_data,
    output logic        cp0_we,
    output logic [4:0]  cp0_waddr,
    output logic [31:0] cp0_wdata,
    output logic        flush,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_EPC    = 3'd1,
        W_CAUSE  = 3'd2,
        W_BADV   = 3'd3,
        W_STATUS = 3'd4,
        REDIRECT = 3'd5,
        ERET_ST  = 3'd6,
        ERET_RD  = 3'd7
    } state_t;

    state_t      state_r, state_nxt_s;

    logic [4:0]  code_r;
    logic        need_badv_r;
    logic [31:0] badv_r;
    logic [31:0] epc_val_r;
    logic        bd_r;
    logic [31:0] status_r;
    logic [31:0] cause_r;
    logic [31:0] epc_r;
    logic        first_r;

    logic        idle_s;
    logic        int_pend_s;
    logic        trig_s;
    logic        eret_trig_s;
    logic [4:0]  code_s;
    logic        need_badv_s;
    logic [31:0] badv_s;
    logic [31:0] epc_val_s;

    assign idle_s      = (state_r == IDLE);
    assign int_pend_s  = cp0_status[0] & ~cp0_status[1]
                       & (|(cp0_cause[15:8] & cp0_status[15:8]));
    assign trig_s      = idle_s & exc_valid & (int_pend_s | (|exc_type));
    assign eret_trig_s = idle_s & exc_valid & eret & ~trig_s;
    // Wraps modulo 2^32 when inst_pc is zero.
    assign epc_val_s   = in_delay_slot ? (inst_pc - 32'd4) : inst_pc;

    // Priority encoder: exception code and BadVAddr source.
    always_comb begin
        code_s      = 5'h00;
        need_badv_s = 1'b0;
        badv_s      = 32'h0000_0000;
        if (int_pend_s) begin
            code_s = 5'h00;
        end else if (exc_type[0]) begin
            code_s      = 5'h04;
            need_badv_s = 1'b1;
            badv_s      = inst_pc;
        end else if (exc_type[1]) begin
            code_s = 5'h0A;
        end else if (exc_type[2]) begin
            code_s = 5'h0C;
        end else if (exc_type[3]) begin
            code_s = 5'h08;
        end else if (exc_type[4]) begin
            code_s = 5'h09;
        end else if (exc_type[5]) begin
            code_s      = 5'h04;
            need_badv_s = 1'b1;
            badv_s      = data_addr;
        end else if (exc_type[6]) begin
            code_s      = 5'h05;
            need_badv_s = 1'b1;
            badv_s      = data_addr;
        end else begin
            code_s = 5'h00;
        end
    end

    // State register and trigger-time capture of the exception context.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            code_r      <= 5'h00;
            need_badv_r <= 1'b0;
            badv_r      <= 32'h0000_0000;
            epc_val_r   <= 32'h0000_0000;
            bd_r        <= 1'b0;
            status_r    <= 32'h0000_0000;
            cause_r     <= 32'h0000_0000;
            epc_r       <= 32'h0000_0000;
            first_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            first_r <= trig_s | eret_trig_s;
            if (trig_s | eret_trig_s) begin
                code_r      <= code_s;
                need_badv_r <= need_badv_s;
                badv_r      <= badv_s;
                epc_val_r   <= epc_val_s;
                bd_r        <= in_delay_slot;
                status_r    <= cp0_status;
                cause_r     <= cp0_cause;
                epc_r       <= cp0_epc;
            end else begin
                code_r <= code_r;
            end
        end
    end

    // Next-state logic; EPC write is skipped for nested exceptions (EXL=1).
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (trig_s) begin
                    state_nxt_s = cp0_status[1] ? W_CAUSE : W_EPC;
                end else if (eret_trig_s) begin
                    state_nxt_s = ERET_ST;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            W_EPC:    state_nxt_s = W_CAUSE;
            W_CAUSE:  state_nxt_s = need_badv_r ? W_BADV : W_STATUS;
            W_BADV:   state_nxt_s = W_STATUS;
            W_STATUS: state_nxt_s = REDIRECT;
            REDIRECT: state_nxt_s = IDLE;
            ERET_ST:  state_nxt_s = ERET_RD;
            ERET_RD:  state_nxt_s = IDLE;
            default:  state_nxt_s = IDLE;
        endcase
    end

    // Output decode; MTC0 pass-through only in IDLE with no trigger present.
    always_comb begin
        cp0_we         = 1'b0;
        cp0_waddr      = 5'd0;
        cp0_wdata      = 32'h0000_0000;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        flush          = first_r;
        stall          = ~idle_s;
        busy           = ~idle_s;
        case (state_r)
            IDLE: begin
                if (rst && mtc0_en && !trig_s && !eret_trig_s) begin
                    cp0_we    = 1'b1;
                    cp0_waddr = mtc0_addr;
                    cp0_wdata = mtc0_data;
                end else begin
                    cp0_we = 1'b0;
                end
            end
            W_EPC: begin
                cp0_we    = 1'b1;
                cp0_waddr = 5'd14;
                cp0_wdata = epc_val_r;
            end
            W_CAUSE: begin
                // A nested exception keeps the original BD bit.
                cp0_we    = 1'b1;
                cp0_waddr = 5'd13;
                cp0_wdata = {(status_r[1] ? cause_r[31] : bd_r),
                             cause_r[30:7], code_r, cause_r[1:0]};
            end
            W_BADV: begin
                cp0_we    = 1'b1;
                cp0_waddr = 5'd8;
                cp0_wdata = badv_r;
            end
            W_STATUS: begin
                cp0_we    = 1'b1;
                cp0_waddr = 5'd12;
                cp0_wdata = status_r | 32'h0000_0002;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = EXC_VECTOR;
            end
            ERET_ST: begin
                cp0_we    = 1'b1;
                cp0_waddr = 5'd12;
                cp0_wdata = status_r & ~32'h0000_0002;
            end
            ERET_RD: begin
                redirect_valid = 1'b1;
                redirect_pc    = epc_r;
            end
            default: begin
                cp0_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [6:0]  exc_type;
    logic        eret;
    logic [31:0] inst_pc;
    logic        in_delay_slot;
    logic [31:0] data_addr;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic        mtc0_en;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        flush;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    int errors = 0;
    int checks = 0;

    exc_ctrl dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_type(exc_type), .eret(eret),
        .inst_pc(inst_pc), .in_delay_slot(in_delay_slot), .data_addr(data_addr),
        .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
        .mtc0_en(mtc0_en), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
        .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .flush(flush), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic we, input logic [4:0] wa,
                             input logic [31:0] wd, input logic fl, input logic st,
                             input logic rv, input logic [31:0] rpc, input logic bz);
        check({tag, ".we"}, {31'd0, cp0_we}, {31'd0, we});
        check({tag, ".waddr"}, {27'd0, cp0_waddr}, {27'd0, wa});
        check({tag, ".wdata"}, cp0_wdata, wd);
        check({tag, ".flush"}, {31'd0, flush}, {31'd0, fl});
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, st});
        check({tag, ".rv"}, {31'd0, redirect_valid}, {31'd0, rv});
        check({tag, ".rpc"}, redirect_pc, rpc);
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, bz});
    endtask

    task automatic clear_req();
        exc_valid = 1'b0;
        exc_type  = 7'd0;
        eret      = 1'b0;
        mtc0_en   = 1'b0;
        mtc0_addr = 5'd0;
        mtc0_data = 32'd0;
    endtask

    // Advance to just after the next rising edge, drop requests, let logic settle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_req();
        #1;
    endtask

    // Present one committing instruction in the current cycle.
    task automatic present(input logic [6:0] ty, input logic er, input logic [31:0] pc,
                           input logic ds, input logic [31:0] da, input logic [31:0] st,
                           input logic [31:0] ca, input logic [31:0] ep);
        exc_valid     = 1'b1;
        exc_type      = ty;
        eret          = er;
        inst_pc       = pc;
        in_delay_slot = ds;
        data_addr     = da;
        cp0_status    = st;
        cp0_cause     = ca;
        cp0_epc       = ep;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        clear_req();
        inst_pc = 32'd0; in_delay_slot = 1'b0; data_addr = 32'd0;
        cp0_status = 32'd0; cp0_cause = 32'd0; cp0_epc = 32'd0;
        next_cycle();
        next_cycle();
        check_all("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        next_cycle();

        // Syscall, EXL=0, no BadVAddr
        present(7'b000_1000, 1'b0, 32'h8000_1000, 1'b0, 32'd0, 32'h0000_FF01, 32'd0, 32'd0);
        check("sys.T.we", {31'd0, cp0_we}, 32'd0);
        next_cycle();
        check_all("sys.T1", 1'b1, 5'd14, 32'h8000_1000, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check_all("sys.T2", 1'b1, 5'd13, 32'h0000_0020, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check_all("sys.T3", 1'b1, 5'd12, 32'h0000_FF03, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check_all("sys.T4", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hBFC0_0380, 1'b1);
        next_cycle();
        check_all("sys.T5", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Data AdES in delay slot: BadVAddr written, redirect at T+5
        present(7'b100_0000, 1'b0, 32'h8000_2004, 1'b1, 32'h8000_0003, 32'h0000_FF01, 32'd0, 32'd0);
        next_cycle();
        check_all("ades.T1", 1'b1, 5'd14, 32'h8000_2000, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check_all("ades.T2", 1'b1, 5'd13, 32'h8000_0014, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check_all("ades.T3", 1'b1, 5'd8, 32'h8000_0003, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check_all("ades.T4", 1'b1, 5'd12, 32'h0000_FF03, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check_all("ades.T5", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hBFC0_0380, 1'b1);
        next_cycle();

        // Interrupt beats Ov
        present(7'b000_0100, 1'b0, 32'h8000_0010, 1'b0, 32'd0, 32'h0000_0401, 32'h0000_0400, 32'd0);
        next_cycle();
        check_all("int.T1", 1'b1, 5'd14, 32'h8000_0010, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check_all("int.T2", 1'b1, 5'd13, 32'h0000_0400, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check_all("int.T3", 1'b1, 5'd12, 32'h0000_0403, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check_all("int.T4", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hBFC0_0380, 1'b1);
        next_cycle();

        // Nested RI with EXL=1: EPC skipped, old BD kept
        present(7'b000_0010, 1'b0, 32'h8000_0100, 1'b0, 32'd0, 32'h0000_0003, 32'h8000_0000, 32'd0);
        next_cycle();
        check_all("nest.T1", 1'b1, 5'd13, 32'h8000_0028, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check_all("nest.T2", 1'b1, 5'd12, 32'h0000_0003, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check_all("nest.T3", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hBFC0_0380, 1'b1);
        next_cycle();

        // ERET
        present(7'd0, 1'b1, 32'h8000_0300, 1'b0, 32'd0, 32'h0000_0403, 32'd0, 32'h8000_0200);
        next_cycle();
        check_all("eret.T1", 1'b1, 5'd12, 32'h0000_0401, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check_all("eret.T2", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h8000_0200, 1'b1);
        next_cycle();
        check_all("eret.T3", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // MTC0 pass-through in IDLE
        cp0_status = 32'd0; cp0_cause = 32'd0;
        mtc0_en = 1'b1; mtc0_addr = 5'd11; mtc0_data = 32'd5;
        #1;
        check_all("mtc0", 1'b1, 5'd11, 32'd5, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        next_cycle();

        // MTC0 coincident with Ov is dropped; MTC0 while busy is ignored
        mtc0_en = 1'b1; mtc0_addr = 5'd11; mtc0_data = 32'd7;
        present(7'b000_0100, 1'b0, 32'h8000_0040, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        check("mtc0ov.T.we", {31'd0, cp0_we}, 32'd0);
        next_cycle();
        check_all("mtc0ov.T1", 1'b1, 5'd14, 32'h8000_0040, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        mtc0_en = 1'b1; mtc0_addr = 5'd11; mtc0_data = 32'd9;
        exc_valid = 1'b1; eret = 1'b1;
        #1;
        check("busy.mtc0.waddr", {27'd0, cp0_waddr}, 32'd14);
        next_cycle();
        check_all("mtc0ov.T2", 1'b1, 5'd13, 32'h0000_0030, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check_all("mtc0ov.T3", 1'b1, 5'd12, 32'h0000_0002, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        next_cycle();
        check("mtc0ov.idle", {31'd0, busy}, 32'd0);

        // Delay-slot EPC wraps at PC 0 (Break)
        present(7'b001_0000, 1'b0, 32'h0000_0000, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
        next_cycle();
        check_all("wrap.T1", 1'b1, 5'd14, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        next_cycle();
        check("wrap.T2.wdata", cp0_wdata, 32'h8000_0024);
        next_cycle();
        next_cycle();
        next_cycle();
        check("wrap.idle", {31'd0, busy}, 32'd0);

        // Reset mid-sequence at T+2
        present(7'b000_1000, 1'b0, 32'h8000_1000, 1'b0, 32'd0, 32'h0000_FF01, 32'd0, 32'd0);
        next_cycle();
        next_cycle();
        check("rst.T2.waddr", {27'd0, cp0_waddr}, 32'd13);
        rst = 1'b0;
        next_cycle();
        check_all("rst.mid", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
